// File: rtl/omap_wr_biu_if.sv
// Write-side bus bundle for the omap BIU: merger input stream plus arbiter write port.
// master = BIU view, slave = the merger/arbiter environment view.
interface omap_wr_biu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              omap_biu2arb_req;
  logic [ADDR_W-1:0] omap_biu2arb_addr;
  logic [DATA_W-1:0] omap_biu2arb_data;
  logic              omap_biu2arb_vld;
  logic              omap_biu2arb_rdy;
  logic [DATA_W-1:0] map_merger2omap_biu_data;
  logic              map_merger2omap_biu_vld;
  logic              map_merger2omap_biu_rdy;

  modport master (
    output omap_biu2arb_req,
    output omap_biu2arb_addr,
    output omap_biu2arb_data,
    output omap_biu2arb_vld,
    input  omap_biu2arb_rdy,
    input  map_merger2omap_biu_data,
    input  map_merger2omap_biu_vld,
    output map_merger2omap_biu_rdy
  );

  modport slave (
    input  omap_biu2arb_req,
    input  omap_biu2arb_addr,
    input  omap_biu2arb_data,
    input  omap_biu2arb_vld,
    output omap_biu2arb_rdy,
    output map_merger2omap_biu_data,
    output map_merger2omap_biu_vld,
    input  map_merger2omap_biu_rdy
  );
endinterface

// File: rtl/omap_wr_biu.sv
// Omap write BIU: buffers one channel map per job and writes it out in planar or interleaved layout.
// Push-to-write latency 1 cycle; merger stalls when the FIFO is full or the map is fully accepted.

module omap_wr_biu_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_dat,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push && !full, pop && !empty})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module omap_wr_biu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_map_size,
  input  logic [7:0]        cfg_out_ch,
  input  logic              cfg_layout,
  input  logic [7:0]        out_ch_cnt,
  input  logic              omap_write_req,
  output logic              omap_busy,
  output logic              omap_done,
  omap_wr_biu_if.master     bus
);
  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       map_size_q;
  logic [15:0]       in_cnt;
  logic [15:0]       out_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] start_stride;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              push;
  logic              pop;
  logic              in_rdy;
  logic              last_pop;
  logic              job_start;

  // Planar places each channel in its own contiguous block; interleaved strides across channels.
  always_comb begin
    start_addr   = cfg_base_addr + ADDR_W'(out_ch_cnt) * ADDR_W'(BYTES);
    start_stride = ADDR_W'(BYTES);
    if (cfg_layout) begin
      start_stride = ADDR_W'(cfg_out_ch) * ADDR_W'(BYTES);
    end else begin
      start_addr = cfg_base_addr
                 + ADDR_W'(out_ch_cnt) * ADDR_W'(cfg_map_size) * ADDR_W'(BYTES);
    end
  end

  assign job_start = (state_q == IDLE) && omap_write_req;
  assign push      = bus.map_merger2omap_biu_vld && in_rdy;
  assign pop       = !fifo_empty && bus.omap_biu2arb_rdy;
  assign last_pop  = pop && (out_cnt == map_size_q - 16'd1);

  omap_wr_biu_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (bus.map_merger2omap_biu_data),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    in_rdy    = 1'b0;
    omap_busy = (state_q != IDLE);
    omap_done = 1'b0;
    bus.omap_biu2arb_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (omap_write_req) begin
          state_d = (cfg_map_size == 16'd0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        bus.omap_biu2arb_req = 1'b1;
        // Readiness ignores a same-cycle pop so a full FIFO always stalls the merger.
        in_rdy = !fifo_full && (in_cnt < map_size_q);
        if (last_pop) begin
          state_d = DONE;
        end
      end
      DONE: begin
        omap_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.map_merger2omap_biu_rdy = in_rdy;
  assign bus.omap_biu2arb_vld        = !fifo_empty;
  assign bus.omap_biu2arb_data       = fifo_empty ? '0 : fifo_head;
  assign bus.omap_biu2arb_addr       = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      map_size_q <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      addr_q     <= '0;
      stride_q   <= '0;
    end else begin
      state_q <= state_d;
      if (job_start) begin
        map_size_q <= cfg_map_size;
        in_cnt     <= '0;
        out_cnt    <= '0;
        addr_q     <= start_addr;
        stride_q   <= start_stride;
      end else begin
        if (push) begin
          in_cnt <= in_cnt + 16'd1;
        end
        if (pop) begin
          out_cnt <= out_cnt + 16'd1;
          addr_q  <= addr_q + stride_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_omap_wr_biu.sv
// Directed bench for omap_wr_biu: planar, interleaved, backpressure, empty map, mid-job reset, random handshakes.
module tb_omap_wr_biu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_base_addr = '0;
  logic [15:0] cfg_map_size = '0;
  logic [7:0]  cfg_out_ch = '0;
  logic        cfg_layout = 1'b0;
  logic [7:0]  out_ch_cnt = '0;
  logic        omap_write_req = 1'b0;
  logic        omap_busy;
  logic        omap_done;

  omap_wr_biu_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  omap_wr_biu #(.DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_map_size   (cfg_map_size),
    .cfg_out_ch     (cfg_out_ch),
    .cfg_layout     (cfg_layout),
    .out_ch_cnt     (out_ch_cnt),
    .omap_write_req (omap_write_req),
    .omap_busy      (omap_busy),
    .omap_done      (omap_done),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_hs_cyc = 0;
  int          stable_viol = 0;
  int          feed_idx = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  logic [31:0] words [0:127];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change only just after posedge, so the negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.omap_biu2arb_vld && bus.omap_biu2arb_rdy) begin
        wr_addr.push_back(bus.omap_biu2arb_addr);
        wr_data.push_back(bus.omap_biu2arb_data);
        last_hs_cyc = cyc;
      end
      if (bus.map_merger2omap_biu_vld && bus.map_merger2omap_biu_rdy) acc_cnt++;
      if (omap_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall && (!bus.omap_biu2arb_vld || bus.omap_biu2arb_addr != prev_addr ||
                         bus.omap_biu2arb_data != prev_data)) stable_viol++;
      prev_stall = bus.omap_biu2arb_vld && !bus.omap_biu2arb_rdy;
      prev_addr  = bus.omap_biu2arb_addr;
      prev_data  = bus.omap_biu2arb_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_merger_rdy"}, {63'd0, bus.map_merger2omap_biu_rdy}, 64'd0);
    chk({tag, "_arb_vld"},    {63'd0, bus.omap_biu2arb_vld}, 64'd0);
    chk({tag, "_arb_req"},    {63'd0, bus.omap_biu2arb_req}, 64'd0);
    chk({tag, "_busy"},       {63'd0, omap_busy}, 64'd0);
    chk({tag, "_done"},       {63'd0, omap_done}, 64'd0);
    chk({tag, "_addr"},       {32'd0, bus.omap_biu2arb_addr}, 64'd0);
    chk({tag, "_data"},       {32'd0, bus.omap_biu2arb_data}, 64'd0);
  endtask

  task automatic start_job(input logic [31:0] base, input logic [15:0] size,
                           input logic [7:0] och, input logic lay, input logic [7:0] ch);
    cfg_base_addr  = base;
    cfg_map_size   = size;
    cfg_out_ch     = och;
    cfg_layout     = lay;
    out_ch_cnt     = ch;
    wr_addr.delete();
    wr_data.delete();
    omap_write_req = 1'b1;
    step();
    omap_write_req = 1'b0;
  endtask

  // Feeds words[feed_idx..n-1] until the job's done pulse is seen.
  task automatic run_job(input int n, input int vld_pct, input int rdy_pct,
                         input int req_at, input int budget);
    int   done0 = done_cnt;
    int   guard = 0;
    logic hs;
    while (done_cnt == done0 && guard < budget) begin
      bus.map_merger2omap_biu_vld  = (feed_idx < n) && ($urandom_range(99) < vld_pct);
      bus.map_merger2omap_biu_data = words[feed_idx];
      bus.omap_biu2arb_rdy         = ($urandom_range(99) < rdy_pct);
      omap_write_req               = (guard == req_at);
      if (guard == req_at) begin
        cfg_base_addr = 32'hDEAD_0000;
        cfg_map_size  = 16'd3;
      end
      hs = bus.map_merger2omap_biu_vld && bus.map_merger2omap_biu_rdy;
      step();
      if (hs) feed_idx++;
      guard++;
    end
    bus.map_merger2omap_biu_vld = 1'b0;
    bus.omap_biu2arb_rdy        = 1'b0;
    omap_write_req              = 1'b0;
    chk("job_timeout", {63'd0, guard < budget}, 64'd1);
    chk("job_done_once", 64'(done_cnt - done0), 64'd1);
    step();
    chk("job_idle_after", {63'd0, omap_busy}, 64'd0);
  endtask

  task automatic check_writes(input string tag, input int n,
                              input logic [31:0] start, input logic [31:0] stride);
    chk({tag, "_count"}, 64'(wr_addr.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {32'd0, wr_addr[i]}, {32'd0, start + 32'(i) * stride});
      chk($sformatf("%s_data%0d", tag, i), {32'd0, wr_data[i]}, {32'd0, words[i]});
    end
  endtask

  initial begin
    int   acc0;
    int   done0;
    logic hs;
    bus.omap_biu2arb_rdy         = 1'b0;
    bus.map_merger2omap_biu_vld  = 1'b0;
    bus.map_merger2omap_biu_data = '0;

    // Reset state
    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Planar: ch 2, 4 words of 4 bytes -> block starts at 0x1020
    for (int i = 0; i < 4; i++) words[i] = 32'hA0 + 32'(i);
    start_job(32'h1000, 16'd4, 8'd8, 1'b0, 8'd2);
    chk("start_busy", {63'd0, omap_busy}, 64'd1);
    chk("start_req",  {63'd0, bus.omap_biu2arb_req}, 64'd1);
    chk("start_rdy",  {63'd0, bus.map_merger2omap_biu_rdy}, 64'd1);
    feed_idx = 0;
    run_job(4, 100, 100, -1, 100);
    check_writes("planar", 4, 32'h1020, 32'h4);
    chk("planar_done_lat", 64'(done_cyc), 64'(last_hs_cyc + 1));

    // Interleaved: 8 channels -> stride 0x20, ch 2 offset 0x8
    for (int i = 0; i < 4; i++) words[i] = 32'hB0 + 32'(i);
    start_job(32'h1000, 16'd4, 8'd8, 1'b1, 8'd2);
    feed_idx = 0;
    run_job(4, 100, 100, -1, 100);
    check_writes("inter", 4, 32'h1008, 32'h20);

    // Backpressure: arbiter stalled, FIFO fills at 8 words
    for (int i = 0; i < 20; i++) words[i] = 32'hC00 + 32'(i);
    acc0 = acc_cnt;
    start_job(32'h2000, 16'd20, 8'd1, 1'b0, 8'd0);
    feed_idx = 0;
    for (int c = 0; c < 30; c++) begin
      bus.map_merger2omap_biu_vld  = (feed_idx < 20);
      bus.map_merger2omap_biu_data = words[feed_idx];
      bus.omap_biu2arb_rdy         = 1'b0;
      hs = bus.map_merger2omap_biu_vld && bus.map_merger2omap_biu_rdy;
      step();
      if (hs) feed_idx++;
    end
    chk("bp_accepts",   64'(acc_cnt - acc0), 64'd8);
    chk("bp_rdy_low",   {63'd0, bus.map_merger2omap_biu_rdy}, 64'd0);
    chk("bp_vld_held",  {63'd0, bus.omap_biu2arb_vld}, 64'd1);
    chk("bp_addr_hold", {32'd0, bus.omap_biu2arb_addr}, 64'h2000);
    chk("bp_data_hold", {32'd0, bus.omap_biu2arb_data}, 64'hC00);
    chk("bp_no_write",  64'(wr_addr.size()), 64'd0);
    run_job(20, 100, 100, -1, 200);
    check_writes("bp", 20, 32'h2000, 32'h4);
    chk("bp_stable", 64'(stable_viol), 64'd0);

    // Zero-length map: busy for exactly one cycle with done
    acc0  = acc_cnt;
    done0 = done_cnt;
    start_job(32'h5000, 16'd0, 8'd4, 1'b0, 8'd1);
    chk("zero_busy", {63'd0, omap_busy}, 64'd1);
    chk("zero_done", {63'd0, omap_done}, 64'd1);
    chk("zero_rdy",  {63'd0, bus.map_merger2omap_biu_rdy}, 64'd0);
    chk("zero_vld",  {63'd0, bus.omap_biu2arb_vld}, 64'd0);
    step();
    chk("zero_busy_off", {63'd0, omap_busy}, 64'd0);
    chk("zero_done_off", {63'd0, omap_done}, 64'd0);
    step();
    chk("zero_done_cnt", 64'(done_cnt - done0), 64'd1);
    chk("zero_no_acc",   64'(acc_cnt - acc0), 64'd0);
    chk("zero_no_write", 64'(wr_addr.size()), 64'd0);

    // Reset after 3 of 10 words
    done0 = done_cnt;
    for (int i = 0; i < 10; i++) words[i] = 32'hE0 + 32'(i);
    start_job(32'h3000, 16'd10, 8'd4, 1'b0, 8'd1);
    feed_idx = 0;
    for (int c = 0; c < 20 && feed_idx < 3; c++) begin
      bus.map_merger2omap_biu_vld  = 1'b1;
      bus.map_merger2omap_biu_data = words[feed_idx];
      bus.omap_biu2arb_rdy         = 1'b0;
      hs = bus.map_merger2omap_biu_rdy;
      step();
      if (hs) feed_idx++;
    end
    chk("rst_fed3", 64'(feed_idx), 64'd3);
    bus.map_merger2omap_biu_vld = 1'b0;
    rst = 1'b1;
    step();
    check_idle_outputs("midrst");
    rst = 1'b0;
    step();
    step();
    chk("midrst_no_done",  64'(done_cnt - done0), 64'd0);
    chk("midrst_no_write", 64'(wr_addr.size()), 64'd0);
    for (int i = 0; i < 10; i++) words[i] = 32'hD0 + 32'(i);
    start_job(32'h3000, 16'd10, 8'd4, 1'b0, 8'd1);
    feed_idx = 0;
    run_job(10, 100, 100, -1, 100);
    check_writes("after_rst", 10, 32'h3028, 32'h4);

    // Random handshakes, interleaved 3 channels, ch 1, with a stray req mid-job
    for (int i = 0; i < 100; i++) words[i] = $urandom;
    start_job(32'h4000, 16'd100, 8'd3, 1'b1, 8'd1);
    feed_idx = 0;
    run_job(100, 60, 55, 5, 2000);
    check_writes("rand", 100, 32'h4004, 32'hC);
    chk("rand_stable", 64'(stable_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/omap_wr_biu.md
# omap_wr_biu

Parametrised output-feature-map write bus interface unit. Accepts one output-channel map per job from the map merger over a valid/ready stream, buffers it in an internal FIFO, and issues word writes to the memory arbiter with addresses generated for either planar (channel-major) or interleaved (pixel-major) omap layout. It sits between the map merger and the arbiter in the accelerator datapath and reports job completion to the top-level controller.

## Interface
- DATA_W, 32, data word width (multiple of 8)
- ADDR_W, 32, byte address width
- FIFO_DEPTH, 8, buffer depth in words (power of two, ≥2)
- BYTES (derived), DATA_W/8, address increment per word

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_base_addr  in  ADDR_W  omap base byte address
- cfg_map_size  in  16  words per channel map
- cfg_out_ch  in  8  total output channels (interleaved stride)
- cfg_layout  in  1  0 = planar, 1 = interleaved
- out_ch_cnt  in  8  channel index of this job
- omap_write_req  in  1  job start pulse
- omap_busy  out  1  job in progress
- omap_done  out  1  one-cycle completion pulse
- omap_biu2arb_req  out  1  bus request to arbiter
- omap_biu2arb_addr  out  ADDR_W  write byte address
- omap_biu2arb_data  out  DATA_W  write data
- omap_biu2arb_vld  out  1  write valid
- omap_biu2arb_rdy  in  1  arbiter accept
- map_merger2omap_biu_data  in  DATA_W  merged pixel word
- map_merger2omap_biu_vld  in  1  merger valid
- map_merger2omap_biu_rdy  out  1  BIU ready

## Operation
- States: IDLE, ACTIVE, DONE.
- IDLE: omap_write_req=1 latches all cfg_* and out_ch_cnt, clears in_cnt/out_cnt, loads start address; next state ACTIVE, or DONE if cfg_map_size==0. Req ignored in ACTIVE/DONE.
- Start address: planar base + out_ch_cnt*map_size*BYTES; interleaved base + out_ch_cnt*BYTES. Stride: planar BYTES; interleaved cfg_out_ch*BYTES. All address arithmetic modulo 2^ADDR_W.
- ACTIVE input side: map_merger2omap_biu_rdy = ACTIVE & !fifo_full & (in_cnt < map_size). vld&rdy pushes word, in_cnt++.
- ACTIVE output side: omap_biu2arb_vld = !fifo_empty; data = FIFO head; addr = current address register. vld&rdy pops, out_cnt++, address += stride.
- Pop of word out_cnt==map_size-1 → DONE. DONE lasts one cycle with omap_done=1, then IDLE.
- omap_busy = (state != IDLE). omap_biu2arb_req = (state == ACTIVE): bus held for the whole job.
- Words beyond map_size are never accepted (rdy stays 0).

## Timing
- Reset: state IDLE, FIFO empty, counters 0, all outputs 0 (rdy, vld, req, busy, done, addr, data).
- Reset mid-job: job abandoned, FIFO flushed, no omap_done.
- Start latency: req at cycle t → busy/req/merger rdy at t+1.
- Pass latency: word pushed at cycle t appears with arb vld at t+1 at earliest.
- Throughput: 1 word/cycle sustained with both sides ready; simultaneous push and pop permitted when not full.
- Full: rdy=0 when FIFO holds FIFO_DEPTH words, even if a pop occurs that cycle.
- Stall: while vld=1 & rdy=0, addr and data hold stable; vld never drops without a handshake.
- Done: final pop at cycle t → omap_done=1 at t+1, busy=0 at t+2. Next req accepted from t+2.

## Test plan
- Planar: base 0x1000, map_size 4, ch 2, DATA 0xA0..0xA3, arb rdy=1 → writes to 0x1020, 0x1024, 0x1028, 0x102C with matching data; done one cycle after last write.
- Interleaved: base 0x1000, out_ch 8, ch 2, map_size 4 → addresses 0x1008, 0x1028, 0x1048, 0x1068.
- Backpressure: FIFO_DEPTH 8, map_size 20, arb rdy=0 for 30 cycles → merger rdy drops after exactly 8 accepts, addr/data stable; release → all 20 written in order, no loss or duplication.
- map_size 0: req → busy one cycle, done pulse at t+1, no vld or merger rdy ever asserted.
- Reset mid-job: rst after 3 of 10 words → all outputs 0 next cycle, no done; new job then completes with correct addresses from word 0.
- Req while busy and random vld/rdy toggling over 100 words → second req ignored; scoreboard matches data and addresses exactly.
